// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : reg_scoreboard
//  Purpose  : Producer-side register-hazard tracker. Records in-flight
//             register writers, counts down their result latency, releases
//             them at writeback, drives the issue-stage Stall and flags
//             writebacks to registers that are not pending.
//  Revision : 1.0  initial release
// ============================================================================
module reg_scoreboard #(
   parameter int LAT_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             IssueValid,
   input  logic [4:0]       IssueRs,
   input  logic [4:0]       IssueRt,
   input  logic             IssueUsesRs,
   input  logic             IssueUsesRt,
   input  logic             IssueRegWrite,
   input  logic [4:0]       IssueWriteReg,
   input  logic [LAT_W-1:0] IssueLatency,
   input  logic             WbValid,
   input  logic [4:0]       WbReg,
   output logic             Stall,
   output logic [5:0]       PendingCount,
   output logic             WbError
);

   // Bit 0 of the pending vector and entry 0 of the counters stay zero:
   // register 0 is never tracked.
   logic [31:0]      r_pending;
   logic [LAT_W-1:0] r_count [32];

   logic [31:0]      w_pending_nxt;
   logic [LAT_W-1:0] w_count_nxt [32];
   logic [5:0]       w_pcount_nxt;
   logic             w_haz_rs;
   logic             w_haz_rt;
   logic             w_haz_waw;
   logic             w_accept;
   logic             w_issue_wr;
   logic             w_wb_valid;
   logic             w_wb_hit;
   logic             w_wb_err;

   // Hazard detection from registered state and current inputs only; a
   // source being written back this cycle is already available.
   always_comb begin
      w_haz_rs   = IssueUsesRs && (IssueRs != 5'd0) && r_pending[IssueRs]
                   && (r_count[IssueRs] != '0)
                   && !(WbValid && (WbReg == IssueRs));
      w_haz_rt   = IssueUsesRt && (IssueRt != 5'd0) && r_pending[IssueRt]
                   && (r_count[IssueRt] != '0)
                   && !(WbValid && (WbReg == IssueRt));
      w_haz_waw  = IssueRegWrite && (IssueWriteReg != 5'd0)
                   && r_pending[IssueWriteReg]
                   && !(WbValid && (WbReg == IssueWriteReg));
      Stall      = IssueValid && (w_haz_rs || w_haz_rt || w_haz_waw);
      w_accept   = IssueValid && !Stall;
      w_issue_wr = w_accept && IssueRegWrite && (IssueWriteReg != 5'd0);
      w_wb_valid = WbValid && (WbReg != 5'd0);
      w_wb_hit   = w_wb_valid && r_pending[WbReg];
      w_wb_err   = w_wb_valid && !r_pending[WbReg];
   end

   // Per-register next state: a new issue beats a same-cycle writeback,
   // otherwise writeback clears, otherwise a nonzero count decrements.
   always_comb begin
      w_pending_nxt = '0;
      for (int r = 0; r < 32; r++) begin
         w_count_nxt[r] = '0;
      end
      for (int r = 1; r < 32; r++) begin
         w_pending_nxt[r] = r_pending[r];
         w_count_nxt[r]   = r_count[r];
         if (w_issue_wr && (IssueWriteReg == 5'(r))) begin
            w_pending_nxt[r] = 1'b1;
            w_count_nxt[r]   = IssueLatency;
         end else if (w_wb_hit && (WbReg == 5'(r))) begin
            w_pending_nxt[r] = 1'b0;
            w_count_nxt[r]   = '0;
         end else if (r_pending[r] && (r_count[r] != '0)) begin
            w_count_nxt[r]   = r_count[r] - LAT_W'(1);
         end
      end
   end

   // Population count of the next pending vector, so the registered count
   // always matches the pending bits it is stored alongside.
   always_comb begin
      w_pcount_nxt = '0;
      for (int r = 1; r < 32; r++) begin
         w_pcount_nxt = w_pcount_nxt + {5'd0, w_pending_nxt[r]};
      end
   end

   // State registers; the writeback error flag is sticky until reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pending    <= '0;
         for (int r = 0; r < 32; r++) begin
            r_count[r] <= '0;
         end
         PendingCount <= '0;
         WbError      <= 1'b0;
      end else begin
         r_pending    <= w_pending_nxt;
         for (int r = 0; r < 32; r++) begin
            r_count[r] <= w_count_nxt[r];
         end
         PendingCount <= w_pcount_nxt;
         if (w_wb_err) begin
            WbError <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_scoreboard
//  Purpose  : Self-checking bench for reg_scoreboard: directed vector table,
//             random traffic against a ready-time reference model, and an
//             asynchronous mid-flight reset sequence.
//  Revision : 1.0  initial release
// ============================================================================
module tb_reg_scoreboard;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       IssueValid = 1'b0;
   logic [4:0] IssueRs = '0;
   logic [4:0] IssueRt = '0;
   logic       IssueUsesRs = 1'b0;
   logic       IssueUsesRt = 1'b0;
   logic       IssueRegWrite = 1'b0;
   logic [4:0] IssueWriteReg = '0;
   logic [2:0] IssueLatency = '0;
   logic       WbValid = 1'b0;
   logic [4:0] WbReg = '0;
   logic       Stall;
   logic [5:0] PendingCount;
   logic       WbError;

   int errors = 0;
   int checks = 0;

   reg_scoreboard #(.LAT_W(3)) dut (
      .clk(clk), .reset(reset),
      .IssueValid(IssueValid), .IssueRs(IssueRs), .IssueRt(IssueRt),
      .IssueUsesRs(IssueUsesRs), .IssueUsesRt(IssueUsesRt),
      .IssueRegWrite(IssueRegWrite), .IssueWriteReg(IssueWriteReg),
      .IssueLatency(IssueLatency), .WbValid(WbValid), .WbReg(WbReg),
      .Stall(Stall), .PendingCount(PendingCount), .WbError(WbError)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       iv;
      logic [4:0] rs;
      logic       urs;
      logic [4:0] rt;
      logic       urt;
      logic       rw;
      logic [4:0] wr;
      logic [2:0] lat;
      logic       wbv;
      logic [4:0] wbr;
      logic       e_stall;
      int         e_pc;
      logic       e_err;
   } vec_t;

   vec_t vecs[18];

   // Reference model: a register is pending until written back, and it
   // blocks readers until the absolute cycle number m_ready[r].
   bit m_pend[32];
   int m_ready[32];
   int m_now;
   bit m_err;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic iv, input logic [4:0] rs, input logic urs,
                               input logic [4:0] rt, input logic urt, input logic rw,
                               input logic [4:0] wr, input logic [2:0] lat,
                               input logic wbv, input logic [4:0] wbr,
                               input logic es, input int epc, input logic eerr);
      vec_t v;
      v.iv = iv; v.rs = rs; v.urs = urs; v.rt = rt; v.urt = urt; v.rw = rw;
      v.wr = wr; v.lat = lat; v.wbv = wbv; v.wbr = wbr;
      v.e_stall = es; v.e_pc = epc; v.e_err = eerr;
      return v;
   endfunction

   task automatic set_in(input logic iv, input logic [4:0] rs, input logic urs,
                         input logic [4:0] rt, input logic urt, input logic rw,
                         input logic [4:0] wr, input logic [2:0] lat,
                         input logic wbv, input logic [4:0] wbr);
      IssueValid = iv; IssueRs = rs; IssueUsesRs = urs; IssueRt = rt;
      IssueUsesRt = urt; IssueRegWrite = rw; IssueWriteReg = wr;
      IssueLatency = lat; WbValid = wbv; WbReg = wbr;
   endtask

   function automatic bit src_blocked(input logic [4:0] r);
      return (r != 5'd0) && m_pend[r] && (m_now < m_ready[r])
             && !(WbValid && (WbReg == r));
   endfunction

   function automatic bit model_stall();
      bit h = 1'b0;
      if (IssueValid) begin
         if (IssueUsesRs && src_blocked(IssueRs)) h = 1'b1;
         if (IssueUsesRt && src_blocked(IssueRt)) h = 1'b1;
         if (IssueRegWrite && (IssueWriteReg != 5'd0) && m_pend[IssueWriteReg]
             && !(WbValid && (WbReg == IssueWriteReg))) h = 1'b1;
      end
      return h;
   endfunction

   function automatic int model_pc();
      int n = 0;
      for (int r = 1; r < 32; r++) n += m_pend[r];
      return n;
   endfunction

   task automatic model_reset();
      for (int r = 0; r < 32; r++) begin
         m_pend[r] = 1'b0;
         m_ready[r] = 0;
      end
      m_now = 0;
      m_err = 1'b0;
   endtask

   task automatic model_update(input bit s);
      if (WbValid && (WbReg != 5'd0)) begin
         if (m_pend[WbReg]) m_pend[WbReg] = 1'b0;
         else m_err = 1'b1;
      end
      if (IssueValid && !s && IssueRegWrite && (IssueWriteReg != 5'd0)) begin
         m_pend[IssueWriteReg] = 1'b1;
         m_ready[IssueWriteReg] = m_now + 1 + int'(IssueLatency);
      end
      m_now++;
   endtask

   // One cycle against the model; entered after inputs are applied,
   // before the falling edge.
   task automatic step_model(input string tag);
      bit s;
      @(negedge clk);
      s = model_stall();
      chk({tag, " stall"}, int'(Stall), int'(s));
      model_update(s);
      @(posedge clk);
      #1;
      chk({tag, " pcount"}, int'(PendingCount), model_pc());
      chk({tag, " wberr"}, int'(WbError), int'(m_err));
   endtask

   initial begin
      int q[$];
      // Directed table: basic latency, zero latency / r0, write-through,
      // WAW resolved by writeback, writeback error, normal release.
      vecs[0]  = mk(1, 0,0, 0,0, 1, 5,2, 0, 0,  0, 1, 0);
      vecs[1]  = mk(1, 5,1, 0,0, 0, 0,0, 0, 0,  1, 1, 0);
      vecs[2]  = mk(1, 5,1, 0,0, 0, 0,0, 0, 0,  1, 1, 0);
      vecs[3]  = mk(1, 5,1, 0,0, 0, 0,0, 0, 0,  0, 1, 0);
      vecs[4]  = mk(1, 0,0, 0,0, 1, 7,0, 0, 0,  0, 2, 0);
      vecs[5]  = mk(1, 0,0, 7,1, 0, 0,0, 0, 0,  0, 2, 0);
      vecs[6]  = mk(1, 0,0, 0,0, 1, 0,3, 0, 0,  0, 2, 0);
      vecs[7]  = mk(1, 0,1, 0,1, 0, 0,0, 0, 0,  0, 2, 0);
      vecs[8]  = mk(1, 0,0, 0,0, 1, 9,3, 0, 0,  0, 3, 0);
      vecs[9]  = mk(1, 9,1, 0,0, 0, 0,0, 1, 9,  0, 2, 0);
      vecs[10] = mk(1, 0,0, 0,0, 1, 4,1, 0, 0,  0, 3, 0);
      vecs[11] = mk(1, 0,0, 0,0, 1, 4,2, 0, 0,  1, 3, 0);
      vecs[12] = mk(1, 0,0, 0,0, 1, 4,2, 0, 0,  1, 3, 0);
      vecs[13] = mk(1, 0,0, 0,0, 1, 4,2, 1, 4,  0, 3, 0);
      vecs[14] = mk(0, 0,0, 0,0, 0, 0,0, 0, 0,  0, 3, 0);
      vecs[15] = mk(0, 0,0, 0,0, 0, 0,0, 1, 12, 0, 3, 1);
      vecs[16] = mk(0, 0,0, 0,0, 0, 0,0, 0, 0,  0, 3, 1);
      vecs[17] = mk(0, 0,0, 0,0, 0, 0,0, 1, 5,  0, 2, 1);

      // Reset state is visible without a clock edge.
      #1;
      chk("reset pcount", int'(PendingCount), 0);
      chk("reset wberr", int'(WbError), 0);
      chk("reset stall", int'(Stall), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      for (int i = 0; i < 18; i++) begin
         set_in(vecs[i].iv, vecs[i].rs, vecs[i].urs, vecs[i].rt, vecs[i].urt,
                vecs[i].rw, vecs[i].wr, vecs[i].lat, vecs[i].wbv, vecs[i].wbr);
         @(negedge clk);
         chk($sformatf("vec%0d stall", i), int'(Stall), int'(vecs[i].e_stall));
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d pcount", i), int'(PendingCount), vecs[i].e_pc);
         chk($sformatf("vec%0d wberr", i), int'(WbError), int'(vecs[i].e_err));
      end

      // Random traffic on a small register window to provoke hazards.
      set_in(0, 0,0, 0,0, 0, 0,0, 0, 0);
      reset = 1'b1;
      #1;
      reset = 1'b0;
      model_reset();
      for (int c = 0; c < 500; c++) begin
         int k;
         q.delete();
         for (int r = 1; r < 32; r++) if (m_pend[r]) q.push_back(r);
         k = int'($urandom_range(0, 99));
         set_in(($urandom_range(0, 3) != 0),
                5'($urandom_range(0, 7)), 1'($urandom),
                5'($urandom_range(0, 7)), 1'($urandom),
                1'($urandom), 5'($urandom_range(0, 7)), 3'($urandom),
                1'b0, 5'd0);
         if (k < 30 && q.size() > 0) begin
            WbValid = 1'b1;
            WbReg = 5'(q[$urandom_range(0, q.size() - 1)]);
         end else if (k < 34) begin
            WbValid = 1'b1;
            WbReg = 5'($urandom_range(0, 31));
         end
         step_model($sformatf("rnd%0d", c));
      end

      // Fill every register, then reset asynchronously mid-cycle.
      set_in(0, 0,0, 0,0, 0, 0,0, 0, 0);
      reset = 1'b1;
      #1;
      reset = 1'b0;
      model_reset();
      for (int r = 1; r < 32; r++) begin
         set_in(1, 0,0, 0,0, 1, 5'(r), 3'd7, 0, 0);
         step_model($sformatf("fill%0d", r));
      end
      chk("full pcount", int'(PendingCount), 31);
      set_in(1, 5'd31,1, 0,0, 0, 0,0, 0, 0);
      #1;
      chk("full stall", int'(Stall), 1);
      reset = 1'b1;
      #1;
      chk("async pcount", int'(PendingCount), 0);
      chk("async stall", int'(Stall), 0);
      chk("async wberr", int'(WbError), 0);
      reset = 1'b0;
      model_reset();
      set_in(0, 0,0, 0,0, 0, 0,0, 1, 5'd3);
      step_model("stale wb");
      set_in(0, 0,0, 0,0, 0, 0,0, 0, 0);
      step_model("sticky");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
